// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the 2A03 bus arbiter (states, grant codes, register addresses).
// With DMC_DMA_EN defined the state set gains the DMC fetch slot.
package nes_bus_pkg;

  localparam logic [15:0] OAM_DMA_REG_DFLT = 16'h4014;
  localparam logic [15:0] OAMDATA_REG_DFLT = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
`ifdef DMC_DMA_EN
    ST_DMC_READ,
`endif
    ST_WRITE
  } dma_state_t;

  typedef enum logic [1:0] {
    GNT_CPU  = 2'd0,
    GNT_OAM  = 2'd1,
    GNT_DMC  = 2'd2,
    GNT_NONE = 2'd3
  } bus_gnt_t;

endpackage

// File: rtl/dma_bus_mux.sv
// Combinational bus grant mux: CPU passthrough, OAM DMA drive, DMC fetch drive, or an idle cycle.
module dma_bus_mux
  import nes_bus_pkg::*;
(
  input  bus_gnt_t    gnt,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_mem_en,
  input  logic        cpu_rw,
  input  logic [15:0] oam_addr,
  input  logic [7:0]  oam_wdata,
  input  logic        oam_rw,
  input  logic [15:0] dmc_addr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_en,
  output logic        bus_rw
);

  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_en    = cpu_mem_en;
    bus_rw    = cpu_rw;
    case (gnt)
      GNT_OAM: begin
        bus_addr  = oam_addr;
        bus_wdata = oam_wdata;
        bus_en    = 1'b1;
        bus_rw    = oam_rw;
      end
      GNT_DMC: begin
        bus_addr  = dmc_addr;
        bus_wdata = oam_wdata;
        bus_en    = 1'b1;
        bus_rw    = RW_READ;
      end
      GNT_NONE: begin
        // alignment cycle: nobody owns the bus, keep the lines quiet
        bus_addr  = oam_addr;
        bus_wdata = oam_wdata;
        bus_en    = 1'b0;
        bus_rw    = RW_READ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA sequencer and CPU bus arbiter: halts the CPU on a $4014 write and copies a page to $2004.
// Optional DMC sample fetch path enabled with `define DMC_DMA_EN.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] OAM_DMA_REG = OAM_DMA_REG_DFLT,
  parameter logic [15:0] OAMDATA_REG = OAMDATA_REG_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_mem_en,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_en,
  output logic        bus_rw,
  input  logic [7:0]  bus_rdata,
`ifdef DMC_DMA_EN
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
`endif
  output logic        dma_busy
);

  dma_state_t  state, state_nxt, slot;
  bus_gnt_t    gnt;
  logic        put;
  logic [7:0]  cnt, page, data;
  logic        oam_trig, cpu_rd, last_wr;
  logic [15:0] oam_addr, dmc_addr_mux;
  logic        oam_rw;

  assign oam_trig = cpu_mem_en && (cpu_rw == RW_WRITE) && (cpu_addr == OAM_DMA_REG);
  assign cpu_rd   = cpu_mem_en && (cpu_rw == RW_READ);
  assign last_wr  = (state == ST_WRITE) && (cnt == 8'hFF);

`ifdef DMC_DMA_EN
  logic dmc_pend, oam_act, dmc_want;
  // a request still held high while dmc_ack is out is the one just served
  assign dmc_want     = dmc_pend || (dmc_req && !dmc_ack && (state != ST_DMC_READ));
  assign slot         = dmc_want ? ST_DMC_READ : ST_READ;
  assign dmc_addr_mux = dmc_addr;
`else
  assign slot         = ST_READ;
  assign dmc_addr_mux = 16'h0000;
`endif

  always_comb begin
    state_nxt = state;
    gnt       = GNT_CPU;
    case (state)
      ST_IDLE: begin
`ifdef DMC_DMA_EN
        if (oam_trig || dmc_want) state_nxt = ST_HALT;
`else
        if (oam_trig) state_nxt = ST_HALT;
`endif
      end
      // the 6502 ignores RDY on write cycles, so only a read ends the halt
      ST_HALT: if (cpu_rd) state_nxt = put ? slot : ST_ALIGN;
      ST_ALIGN: begin
        gnt = GNT_NONE;
`ifdef DMC_DMA_EN
        if (dmc_want)     state_nxt = ST_DMC_READ;
        else if (oam_act) state_nxt = ST_READ;
        else              state_nxt = ST_IDLE;
`else
        state_nxt = ST_READ;
`endif
      end
      ST_READ: begin
        gnt       = GNT_OAM;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        gnt = GNT_OAM;
`ifdef DMC_DMA_EN
        state_nxt = last_wr ? (dmc_want ? ST_DMC_READ : ST_IDLE) : slot;
`else
        state_nxt = last_wr ? ST_IDLE : ST_READ;
`endif
      end
`ifdef DMC_DMA_EN
      ST_DMC_READ: begin
        gnt       = GNT_DMC;
        state_nxt = ST_ALIGN;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign oam_addr = (state == ST_WRITE) ? OAMDATA_REG : {page, cnt};
  assign oam_rw   = (state == ST_WRITE) ? RW_WRITE : RW_READ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      put      <= 1'b0;
      cnt      <= 8'h00;
      page     <= 8'h00;
      data     <= 8'h00;
      cpu_rdy  <= 1'b1;
      dma_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      put      <= ~put;
      cpu_rdy  <= (state_nxt == ST_IDLE);
      dma_busy <= (state_nxt != ST_IDLE);
      if (state == ST_IDLE && oam_trig) begin
        page <= cpu_wdata;
        cnt  <= 8'h00;
      end
      if (state == ST_READ)  data <= bus_rdata;
      if (state == ST_WRITE) cnt  <= cnt + 8'd1;
    end
  end

`ifdef DMC_DMA_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dmc_pend <= 1'b0;
      oam_act  <= 1'b0;
      dmc_ack  <= 1'b0;
      dmc_data <= 8'h00;
    end else begin
      dmc_ack <= (state == ST_DMC_READ);
      if (state == ST_DMC_READ) begin
        dmc_data <= bus_rdata;
        dmc_pend <= 1'b0;
      end else if (dmc_want) begin
        dmc_pend <= 1'b1;
      end
      if (state == ST_IDLE && oam_trig) oam_act <= 1'b1;
      else if (last_wr)                 oam_act <= 1'b0;
    end
  end
`endif

  dma_bus_mux u_mux (
    .gnt        (gnt),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_mem_en (cpu_mem_en),
    .cpu_rw     (cpu_rw),
    .oam_addr   (oam_addr),
    .oam_wdata  (data),
    .oam_rw     (oam_rw),
    .dmc_addr   (dmc_addr_mux),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_en     (bus_en),
    .bus_rw     (bus_rw)
  );

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: reset, both parities, halt-on-write, mid-transfer reset, DMC fetches.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_mem_en, cpu_rw, cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_en, bus_rw, dma_busy;
`ifdef DMC_DMA_EN
  logic        dmc_req, dmc_ack;
  logic [15:0] dmc_addr;
  logic [7:0]  dmc_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic tput;

  always #5 clk = ~clk;

  // reference get/put parity, 0 in the first cycle after reset
  always @(posedge clk) tput <= rst ? 1'b0 : ~tput;

  // memory model: every byte is a fixed function of its address
  assign bus_rdata = bus_addr[7:0] ^ bus_addr[15:8] ^ 8'h3C;

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_mem_en (cpu_mem_en),
    .cpu_rw     (cpu_rw),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_en     (bus_en),
    .bus_rw     (bus_rw),
    .bus_rdata  (bus_rdata),
`ifdef DMC_DMA_EN
    .dmc_req    (dmc_req),
    .dmc_addr   (dmc_addr),
    .dmc_ack    (dmc_ack),
    .dmc_data   (dmc_data),
`endif
    .dma_busy   (dma_busy)
  );

  task automatic drive(input logic en, input logic rw, input logic [15:0] a, input logic [7:0] d);
    cpu_mem_en = en;
    cpu_rw     = rw;
    cpu_addr   = a;
    cpu_wdata  = d;
  endtask

  task automatic align_parity(input bit want_put);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h8000, 8'h00);
    for (int i = 0; i < 4 && tput !== want_put; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h1234, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cpu_rdy, dma_busy} !== 2'b10)
      begin n_bad++; $display("FAIL reset_rdy_busy: got %b, want 10", {cpu_rdy, dma_busy}); end
    n_cmp++;
    if ({bus_en, bus_rw, bus_addr} !== {2'b11, 16'h1234})
      begin n_bad++; $display("FAIL reset_pass_rd: got %h, want %h", {bus_en, bus_rw, bus_addr}, {2'b11, 16'h1234}); end
    // a $4014 write under reset must not start anything
    drive(1'b1, 1'b0, 16'h4014, 8'h55);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cpu_rdy, dma_busy, bus_en, bus_rw, bus_addr, bus_wdata} !== {4'b1010, 16'h4014, 8'h55})
      begin n_bad++; $display("FAIL reset_pass_wr: got %h, want %h",
        {cpu_rdy, dma_busy, bus_en, bus_rw, bus_addr, bus_wdata}, {4'b1010, 16'h4014, 8'h55}); end
`ifdef DMC_DMA_EN
    n_cmp++;
    if (dmc_ack !== 1'b0) begin n_bad++; $display("FAIL reset_dmc_ack: got %b, want 0", dmc_ack); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'h8000, 8'h00);
  endtask

  // One full OAM transfer checked cycle by cycle. n_wr CPU writes (to $4014, ignored) follow the
  // trigger; abort_rd >= 0 resets at that READ; dmc_w >= 0 raises a DMC request during that WRITE.
  task automatic run_dma(input logic [7:0] pg, input bit want_put, input int n_wr,
                         input int abort_rd, input int dmc_w, input string tag);
    int a, k0, kd, klast, rel, j, mode;
    bit done;
    logic [27:0] obs, expv, msk;
    logic [15:0] ca;
    logic [7:0]  cw;
    logic        crw;
    a     = ((want_put ^ ((n_wr + 1) % 2 == 1)) != 0) ? 0 : 1;
    k0    = n_wr + 2 + a;
    kd    = (dmc_w >= 0) ? k0 + 2 * dmc_w + 2 : -10;
    klast = k0 + 511 + ((dmc_w >= 0) ? 2 : 0);
    done  = 1'b0;
    align_parity(want_put);
    drive(1'b1, 1'b0, 16'h4014, pg);
    for (int k = 1; k <= klast + 1 && !done; k++) begin
      @(posedge clk); #1;
      if (k <= n_wr) begin ca = 16'h4014; cw = 8'hE0 + 8'(k); crw = 1'b0; end
      else           begin ca = 16'h8000 + 16'(k); cw = 8'h00; crw = 1'b1; end
      drive(1'b1, crw, ca, cw);
      @(negedge clk);
      rel = k - k0; j = 0; mode = 0;
      if (k > klast)     mode = 5;
      else if (k < k0)   mode = (a == 1 && k == k0 - 1) ? 1 : 0;
      else if (k == kd)  mode = 4;
      else if (dmc_w >= 0 && k == kd + 1) mode = 1;
      else begin
        if (dmc_w >= 0 && k > kd) rel = rel - 2;
        j    = rel / 2;
        mode = (rel % 2 == 1) ? 3 : 2;
      end
      msk = '1;
      case (mode)
        0: expv = {2'b01, 1'b1, crw, ca, cw};
        1: begin expv = {2'b01, 1'b0, 25'd0}; msk = {3'b111, 25'd0}; end
        2: begin expv = {2'b01, 2'b11, pg, 8'(j), 8'h00}; msk = {20'hFFFFF, 8'h00}; end
        3: expv = {2'b01, 2'b10, 16'h2004, 8'(j) ^ pg ^ 8'h3C};
        4: begin expv = {2'b01, 2'b11, 16'hC000, 8'h00}; msk = {20'hFFFFF, 8'h00}; end
        default: expv = {2'b10, 1'b1, crw, ca, cw};
      endcase
      obs = {cpu_rdy, dma_busy, bus_en, bus_rw, bus_addr, bus_wdata};
      n_cmp++;
      if ((obs & msk) !== (expv & msk)) begin
        n_bad++;
        $display("FAIL %s k=%0d mode=%0d: got %h, want %h (mask %h)", tag, k, mode, obs, expv, msk);
      end
`ifdef DMC_DMA_EN
      if (dmc_w >= 0) begin
        n_cmp++;
        if (dmc_ack !== (k == kd + 1))
          begin n_bad++; $display("FAIL %s_ack k=%0d: got %b, want %b", tag, k, dmc_ack, (k == kd + 1)); end
        if (k == kd + 1) begin
          n_cmp++;
          if (dmc_data !== 8'hFC) begin n_bad++; $display("FAIL %s_data: got %h, want fc", tag, dmc_data); end
          dmc_req = 1'b0;
        end
        if (mode == 3 && j == dmc_w) begin dmc_addr = 16'hC000; dmc_req = 1'b1; end
      end
`endif
      if (abort_rd >= 0 && mode == 2 && j == abort_rd) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 16'h1234, 8'h00);
        @(negedge clk);
        n_cmp++;
        if ({cpu_rdy, dma_busy, bus_en, bus_rw, bus_addr} !== {4'b1011, 16'h1234})
          begin n_bad++; $display("FAIL %s_abort: got %h, want %h", tag,
            {cpu_rdy, dma_busy, bus_en, bus_rw, bus_addr}, {4'b1011, 16'h1234}); end
        done = 1'b1;
      end
    end
  endtask

  task automatic test_dma_get;       run_dma(8'h02, 1'b0, 0, -1, -1, "dma_get");  endtask
  task automatic test_dma_put;       run_dma(8'h05, 1'b1, 0, -1, -1, "dma_put");  endtask
  task automatic test_halt_writes;   run_dma(8'h07, 1'b0, 2, -1, -1, "halt_wr");  endtask
  task automatic test_reset_mid;
    run_dma(8'h02, 1'b0, 0, 100, -1, "abort");
    run_dma(8'h03, 1'b0, 0, -1, -1, "restart");
  endtask

`ifdef DMC_DMA_EN
  task automatic test_dmc_mid;       run_dma(8'h02, 1'b0, 0, -1, 10, "dmc_mid");  endtask

  task automatic test_dmc_idle(input bit want_put);
    int low, kd, acks, rds;
    low = want_put ? 4 : 3;
    kd  = want_put ? 3 : 2;
    acks = 0; rds = 0;
    align_parity(want_put);
    dmc_addr = 16'hC000;
    dmc_req  = 1'b1;
    for (int k = 1; k <= low + 1; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 16'h9000 + 16'(k), 8'h00);
      @(negedge clk);
      n_cmp++;
      if (cpu_rdy !== (k > low))
        begin n_bad++; $display("FAIL dmc_idle_rdy p=%0d k=%0d: got %b, want %b", want_put, k, cpu_rdy, (k > low)); end
      if (bus_en && bus_rw && bus_addr == 16'hC000) rds++;
      if (k == kd) begin
        n_cmp++;
        if ({bus_en, bus_rw, bus_addr} !== {2'b11, 16'hC000})
          begin n_bad++; $display("FAIL dmc_idle_rd p=%0d: got %h, want %h", want_put, {bus_en, bus_rw, bus_addr}, {2'b11, 16'hC000}); end
      end
      if (dmc_ack === 1'b1) begin
        acks++;
        dmc_req = 1'b0;
        n_cmp++;
        if (dmc_data !== 8'hFC) begin n_bad++; $display("FAIL dmc_idle_data: got %h, want fc", dmc_data); end
      end
    end
    n_cmp++;
    if (acks != 1 || rds != 1)
      begin n_bad++; $display("FAIL dmc_idle_once p=%0d: got acks=%0d reads=%0d, want 1/1", want_put, acks, rds); end
    dmc_req = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
`ifdef DMC_DMA_EN
    dmc_req  = 1'b0;
    dmc_addr = 16'h0000;
`endif
    test_reset;
    test_dma_get;
    test_dma_put;
    test_halt_writes;
    test_reset_mid;
`ifdef DMC_DMA_EN
    test_dmc_mid;
    test_dmc_idle(1'b0);
    test_dmc_idle(1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Bus arbiter and sequencer that shares the 2A03 CPU memory bus between the CPU core and the on-chip sprite (OAM) DMA engine. A CPU write to $4014 starts the transfer. The block halts the CPU through `cpu_rdy` and aligns to the get/put cycle parity. It then performs 256 read/write pairs from page $XX00–$XXFF to $2004 before returning the bus to the CPU. It sits between the CPU control/datapath and the external memory bus.

## Interface
Parameters:
- `OAM_DMA_REG`, 16'h4014, address whose write triggers DMA
- `OAMDATA_REG`, 16'h2004, DMA write destination

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `cpu_addr`  in  16  CPU address
- `cpu_wdata`  in  8  CPU write data
- `cpu_mem_en`  in  1  CPU bus cycle valid
- `cpu_rw`  in  1  1=read, 0=write (CPU convention)
- `cpu_rdy`  out  1  0 halts CPU on its next read cycle
- `bus_addr`  out  16  arbitrated address
- `bus_wdata`  out  8  arbitrated write data
- `bus_en`  out  1  arbitrated cycle valid
- `bus_rw`  out  1  arbitrated direction
- `bus_rdata`  in  8  read data, valid same cycle
- `dma_busy`  out  1  high from HALT until the last WRITE, inclusive
- `dmc_req`  in  1  DMC sample fetch request, level (only with `DMC_DMA_EN`)
- `dmc_addr`  in  16  DMC fetch address (only with `DMC_DMA_EN`)
- `dmc_ack`  out  1  one-cycle pulse; `dmc_data` valid (only with `DMC_DMA_EN`)
- `dmc_data`  out  8  fetched byte (only with `DMC_DMA_EN`)

## Operation
- Parity flop `put` toggles every cycle. Reset value is 0 (get). READ occurs only on get cycles; WRITE occurs only on put cycles.
- States: IDLE, HALT, ALIGN, READ, WRITE, plus DMC_READ with the macro.
- IDLE:
  - The bus passes the CPU signals straight through.
  - `cpu_mem_en & !cpu_rw & cpu_addr==OAM_DMA_REG` latches `page<=cpu_wdata` and `cnt<=0`, then goes to HALT.
- HALT:
  - `cpu_rdy=0`, and the bus still passes the CPU through.
  - A CPU write cycle (6502 cannot stop on a write) keeps the block in HALT.
  - On the first CPU read cycle (the dummy cycle), go to READ if `put==1` now, else go to ALIGN.
- ALIGN: one idle cycle with `bus_en=0`, then READ.
- READ: `bus_addr={page,cnt}`, `bus_rw=1`, `bus_en=1`. Latch `bus_rdata` into `data`, then go to WRITE.
- WRITE: `bus_addr=OAMDATA_REG`, `bus_wdata=data`, `bus_rw=0`, `bus_en=1`. Then `cnt<=cnt+1`.
  - If `cnt==8'hFF`, go to IDLE; otherwise go to READ.
- `cnt` is 8 bits and wraps after 255. The page is never incremented, so a transfer never crosses its page.
- `$4014` writes while not in IDLE are ignored; the CPU is halted in that case anyway.
- Reset in any state takes effect on the next edge:
  - state=IDLE, `cpu_rdy=1`, `dma_busy=0`
  - `put=0`, `cnt=0`, `page=0`, `data=0`
  - `dmc_ack=0`
  - the transfer is abandoned.

## Timing
- Reset values: `cpu_rdy=1`, `dma_busy=0`, `dmc_ack=0`. `bus_*` equal the CPU inputs, because the bus output is a combinational mux on state.
- `$4014` write in cycle N, with a CPU read in N+1:
  - If `put==0` at N: HALT at N+1, first READ at N+2, last WRITE at N+513. `cpu_rdy` is low for 513 cycles.
  - If `put==1` at N: ALIGN is inserted, the last WRITE is at N+514, and `cpu_rdy` is low for 514 cycles.
- `cpu_rdy` returns high in the cycle after the last WRITE.
- Each CPU write cycle that occurs in HALT adds one cycle.
- `cpu_rdy` and `dma_busy` are registered outputs.

## Configuration
Macro `DMC_DMA_EN` controls the DMC fetch path.

Defined:
- `dmc_*` ports exist.
- A `dmc_req` seen in IDLE takes the HALT path with DMC pending.
- DMC has priority. A pending request replaces the next READ slot (a get cycle) with DMC_READ:
  - `bus_addr=dmc_addr`, `bus_rw=1`.
  - `dmc_data<=bus_rdata`, and `dmc_ack` pulses the following cycle.
- One put cycle follows DMC_READ. Any OAM transfer then resumes at an unchanged `cnt`, delayed by 2 cycles.
- A stand-alone DMC fetch holds `cpu_rdy` low for 3 or 4 cycles, depending on parity.
- The requester must drop `dmc_req` on `dmc_ack`.

Undefined:
- The ports and the state are absent.
- Behaviour is exactly as specified above.

## Structure
- Shared package `nes_bus_pkg` holds:
  - the state enum `dma_state_t`
  - the `OAM_DMA_REG` and `OAMDATA_REG` defaults
  - the `RW_READ=1` and `RW_WRITE=0` constants.
- One sub-module, `dma_bus_mux`: a combinational grant mux selecting CPU, OAM or DMC drive of `bus_*` from a 2-bit grant code.
- The FSM, parity, counter and latches stay in the top module.

## Test plan
- Reset, then a `$4014=8'h02` write with `put==0`:
  - `cpu_rdy` is low for 513 cycles.
  - Bus reads are $0200..$02FF in order.
  - 256 writes go to $2004 with matching data.
  - `dma_busy` falls after the WRITE from $02FF.
- The same write issued with `put==1`:
  - One ALIGN cycle with `bus_en=0`.
  - 514 cycles total.
  - The first READ lands on a get cycle.
- CPU write cycles after the trigger (two writes, e.g. a JSR push) keep the block in HALT for 2 extra cycles, then the normal sequence runs.
- Reset asserted at READ #100:
  - Next cycle: `cpu_rdy=1`, `dma_busy=0`, bus passthrough.
  - A new `$4014=8'h03` write restarts from $0300.
- `DMC_DMA_EN` with `dmc_req` raised during WRITE #10, `dmc_addr=16'hC000`:
  - The next get cycle reads $C000 and `dmc_ack` pulses once.
  - The OAM read of $XX0B follows 2 cycles later.
  - Total OAM time is +2 cycles.
- `DMC_DMA_EN` with `dmc_req` raised in IDLE: `cpu_rdy` is low for 3 or 4 cycles, depending on parity, with one read of `dmc_addr` and one `dmc_ack`.
